// File: rtl/display_timings_gen_pkg.sv
// Shared types and helpers for the display timing generator.
`timescale 1ns/1ps
package display_timings_gen_pkg;

  typedef logic signed [15:0] coord_t;

  // Map an internal "sync active" flag onto the configured output polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return pol ? active : ~active;
  endfunction

endpackage

// File: rtl/display_timings_gen_axis.sv
// One timing axis: signed position counter (porches/sync negative, active >= 0) plus sync decode.
`timescale 1ns/1ps
module display_timings_gen_axis
  import display_timings_gen_pkg::*;
#(
  parameter int RES  = 640,
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48,
  parameter bit POL  = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   advance,
  output coord_t pos,
  output logic   sync
);

  localparam coord_t STA      = coord_t'(-(FP + SYNC + BP));
  localparam coord_t SYNC_STA = coord_t'(-(FP + SYNC + BP) + FP);
  localparam coord_t SYNC_END = coord_t'(-(FP + SYNC + BP) + FP + SYNC - 1);
  localparam coord_t END      = coord_t'(RES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= STA;
    end else if (advance) begin
      pos <= (pos == END) ? STA : pos + 16'sd1;
    end
  end

  always_comb begin
    sync = sync_level((pos >= SYNC_STA) && (pos <= SYNC_END), POL);
  end

endmodule

// File: rtl/display_timings_gen.sv
// Free-running video timing generator: hsync/vsync/DE/frame strobe and signed screen coordinates.
`timescale 1ns/1ps
module display_timings_gen
  import display_timings_gen_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame,
  output logic [15:0] o_sx,
  output logic [15:0] o_sy
);

  localparam coord_t H_STA = coord_t'(-(H_FP + H_SYNC + H_BP));
  localparam coord_t V_STA = coord_t'(-(V_FP + V_SYNC + V_BP));
  localparam coord_t H_END = coord_t'(H_RES - 1);

  coord_t sx;
  coord_t sy;
  logic   line_end;

  display_timings_gen_axis #(
    .RES (H_RES),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP),
    .POL (H_POL)
  ) u_h (
    .clk    (i_pix_clk),
    .rst    (i_rst),
    .advance(1'b1),
    .pos    (sx),
    .sync   (o_hs)
  );

  // The vertical axis steps once per line, on the same clock the horizontal axis wraps.
  display_timings_gen_axis #(
    .RES (V_RES),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP),
    .POL (V_POL)
  ) u_v (
    .clk    (i_pix_clk),
    .rst    (i_rst),
    .advance(line_end),
    .pos    (sy),
    .sync   (o_vs)
  );

  always_comb begin
    line_end = (sx == H_END);
    o_de     = (sx >= 16'sd0) && (sy >= 16'sd0);
    o_frame  = (sx == H_STA) && (sy == V_STA);
    o_sx     = sx;
    o_sy     = sy;
  end

endmodule

// File: tb/tb_display_timings_gen.sv
// Bench: checkpoint tables for 480p and 720p, plus a per-cycle scoreboard on a small mode.
`timescale 1ns/1ps
module tb_display_timings_gen;

  typedef struct packed {
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic hs;
    logic vs;
    logic de;
    logic fr;
  } obs_t;

  typedef struct {
    int    inst;
    int    n;
    obs_t  exp;
    string name;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk_a = 1'b0, clk_b = 1'b0, clk_c = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  always #19.84 clk_a = ~clk_a;
  always #6.735 clk_b = ~clk_b;
  always #5     clk_c = ~clk_c;

  logic        hs_a, vs_a, de_a, fr_a, hs_b, vs_b, de_b, fr_b, hs_c, vs_c, de_c, fr_c;
  logic [15:0] sx_a, sy_a, sx_b, sy_b, sx_c, sy_c;
  obs_t        obs_a, obs_b, obs_c;
  assign obs_a = {sx_a, sy_a, hs_a, vs_a, de_a, fr_a};
  assign obs_b = {sx_b, sy_b, hs_b, vs_b, de_b, fr_b};
  assign obs_c = {sx_c, sy_c, hs_c, vs_c, de_c, fr_c};

  display_timings_gen u_480 (
    .i_pix_clk(clk_a), .i_rst(rst_a), .o_hs(hs_a), .o_vs(vs_a),
    .o_de(de_a), .o_frame(fr_a), .o_sx(sx_a), .o_sy(sy_a)
  );

  display_timings_gen #(
    .H_RES(1280), .V_RES(720), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_FP(5), .V_SYNC(5), .V_BP(20), .H_POL(1'b1), .V_POL(1'b1)
  ) u_720 (
    .i_pix_clk(clk_b), .i_rst(rst_b), .o_hs(hs_b), .o_vs(vs_b),
    .o_de(de_b), .o_frame(fr_b), .o_sx(sx_b), .o_sy(sy_b)
  );

  // Tiny mode: line 14 cycles, frame 8 lines = 112 cycles.
  localparam int SH_RES = 8, SH_FP = 2, SH_SYNC = 3, SH_BP = 1;
  localparam int SV_RES = 4, SV_FP = 1, SV_SYNC = 2, SV_BP = 1;
  localparam int S_FRAME = (SH_RES + SH_FP + SH_SYNC + SH_BP) * (SV_RES + SV_FP + SV_SYNC + SV_BP);

  display_timings_gen #(
    .H_RES(SH_RES), .V_RES(SV_RES), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .H_POL(1'b1), .V_POL(1'b0)
  ) u_small (
    .i_pix_clk(clk_c), .i_rst(rst_c), .o_hs(hs_c), .o_vs(vs_c),
    .o_de(de_c), .o_frame(fr_c), .o_sx(sx_c), .o_sy(sy_c)
  );

  vec_t vec[$];

  task automatic add(input int inst, input int n, input int sx, input int sy,
                     input bit hs, input bit vs, input bit de, input bit fr, input string nm);
    vec_t v;
    v.inst = inst;
    v.n    = n;
    v.exp  = {16'(sx), 16'(sy), hs, vs, de, fr};
    v.name = nm;
    vec.push_back(v);
  endtask

  function automatic string fmt(input obs_t o);
    return $sformatf("sx=%0d sy=%0d hs=%0b vs=%0b de=%0b frame=%0b",
                     o.sx, o.sy, o.hs, o.vs, o.de, o.fr);
  endfunction

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
    end
  endtask

  task automatic wait_neg(input int inst);
    if (inst == 0) @(negedge clk_a);
    else           @(negedge clk_b);
  endtask

  // n counts negedges since reset release; n=0 still shows the reset state.
  task automatic run_table(input int inst);
    int   n = 0;
    obs_t o;
    foreach (vec[i]) begin
      if (vec[i].inst == inst) begin
        while (n < vec[i].n) begin
          wait_neg(inst);
          n++;
        end
        o = (inst == 0) ? obs_a : obs_b;
        check(vec[i].name, o, vec[i].exp);
      end
    end
  endtask

  initial begin
    // 480p: H_STA=-160, hsync low sx -144..-49, V_STA=-45, vsync low sy -35..-34.
    add(0, 0,     -160, -45, 1, 1, 0, 1, "480_reset");
    add(0, 15,    -145, -45, 1, 1, 0, 0, "480_hs_before");
    add(0, 16,    -144, -45, 0, 1, 0, 0, "480_hs_first");
    add(0, 111,   -49,  -45, 0, 1, 0, 0, "480_hs_last");
    add(0, 112,   -48,  -45, 1, 1, 0, 0, "480_hs_after");
    add(0, 799,   639,  -45, 1, 1, 0, 0, "480_line_end");
    add(0, 800,   -160, -44, 1, 1, 0, 0, "480_line_wrap");
    add(0, 7999,  639,  -36, 1, 1, 0, 0, "480_vs_before");
    add(0, 8000,  -160, -35, 1, 0, 0, 0, "480_vs_first");
    add(0, 9599,  639,  -34, 1, 0, 0, 0, "480_vs_last");
    add(0, 9600,  -160, -33, 1, 1, 0, 0, "480_vs_after");
    add(0, 36159, -1,   0,   1, 1, 0, 0, "480_de_before");
    add(0, 36160, 0,    0,   1, 1, 1, 0, "480_de_first");
    add(0, 36799, 639,  0,   1, 1, 1, 0, "480_de_last");
    add(0, 36800, -160, 1,   1, 1, 0, 0, "480_de_next_line");
    // 720p: H_STA=-370, hsync high sx -260..-221, V_STA=-30, vsync high sy -25..-21.
    add(1, 0,     -370, -30, 0, 0, 0, 1, "720_reset");
    add(1, 109,   -261, -30, 0, 0, 0, 0, "720_hs_before");
    add(1, 110,   -260, -30, 1, 0, 0, 0, "720_hs_first");
    add(1, 149,   -221, -30, 1, 0, 0, 0, "720_hs_last");
    add(1, 150,   -220, -30, 0, 0, 0, 0, "720_hs_after");
    add(1, 1649,  1279, -30, 0, 0, 0, 0, "720_line_end");
    add(1, 1650,  -370, -29, 0, 0, 0, 0, "720_line_wrap");
    add(1, 8250,  -370, -25, 0, 1, 0, 0, "720_vs_first");
    add(1, 16499, 1279, -21, 0, 1, 0, 0, "720_vs_last");
    add(1, 16500, -370, -20, 0, 0, 0, 0, "720_vs_after");

    fork
      begin : proc_480
        rst_a = 1'b1;
        repeat (3) @(posedge clk_a);
        @(negedge clk_a);
        rst_a = 1'b0;
        run_table(0);
      end
      begin : proc_720
        rst_b = 1'b1;
        repeat (3) @(posedge clk_b);
        @(negedge clk_b);
        rst_b = 1'b0;
        run_table(1);
      end
      begin : proc_small
        obs_t q[$];
        obs_t e;
        int   mx = 0, my = 0, last_fr = -1;
        bit   mid_done = 1'b0, hs_act, vs_act;
        @(negedge clk_c);
        for (int cyc = 0; cyc < 700; cyc++) begin
          rst_c = (cyc < 3);
          if (!mid_done && cyc > 350 && mx == 3 && my == 2) begin
            rst_c    = 1'b1;
            mid_done = 1'b1;
          end
          // Reference model: state after the coming posedge.
          if (rst_c) begin
            mx = -(SH_FP + SH_SYNC + SH_BP);
            my = -(SV_FP + SV_SYNC + SV_BP);
          end else if (mx == SH_RES - 1) begin
            mx = -(SH_FP + SH_SYNC + SH_BP);
            my = (my == SV_RES - 1) ? -(SV_FP + SV_SYNC + SV_BP) : my + 1;
          end else begin
            mx = mx + 1;
          end
          hs_act = (mx >= -(SH_SYNC + SH_BP)) && (mx < -SH_BP);
          vs_act = (my >= -(SV_SYNC + SV_BP)) && (my < -SV_BP);
          q.push_back({16'(mx), 16'(my), hs_act, ~vs_act, (mx >= 0 && my >= 0),
                       (mx == -(SH_FP + SH_SYNC + SH_BP) && my == -(SV_FP + SV_SYNC + SV_BP))});
          @(negedge clk_c);
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL small_queue: got empty scoreboard, expected one entry");
          end else begin
            e = q.pop_front();
            check(rst_c && cyc > 3 ? "small_mid_reset" : "small_cycle", obs_c, e);
          end
          if (rst_c) begin
            last_fr = cyc;
          end else if (fr_c === 1'b1) begin
            if (last_fr >= 0) begin
              n_checks++;
              if (cyc - last_fr != S_FRAME) begin
                n_fail++;
                $display("FAIL small_frame_period: got %0d cycles, expected %0d",
                         cyc - last_fr, S_FRAME);
              end
            end
            last_fr = cyc;
          end
          if (n_fail > 50) break;
        end
        rst_c = 1'b0;
        n_checks++;
        if (!mid_done) begin
          n_fail++;
          $display("FAIL small_mid_reset_reached: got 0, expected 1");
        end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
